// File: rtl/regfile_pkg.sv
// Shared types and constants for the scrubbed register file.
package regfile_pkg;

  typedef enum logic {IDLE, SCRUB} scrub_state_t;

  localparam int ADDR_W = 5;

endpackage

// File: rtl/regfile_scrub_fsm.sv
// Scrub sequencer: walks ptr from 1 to DEPTH-1, asserting clr_we for one register per cycle.
// state | meaning
// IDLE  | normal operation, clr sampled each cycle
// SCRUB | zeroing reg[ptr] this cycle, busy high, clr ignored
module regfile_scrub_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic             busy,
  output logic [PTR_W-1:0] ptr,
  output logic             clr_we
);

  // Compare against a constant of ptr width so a non-power-of-2 DEPTH never wraps.
  localparam logic [PTR_W-1:0] PTR_FIRST = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

  scrub_state_t     state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= PTR_FIRST;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = SCRUB;
          ptr_d   = PTR_FIRST;
        end
      end
      SCRUB: begin
        if (ptr_q == PTR_LAST) begin
          state_d = IDLE;
          ptr_d   = PTR_FIRST;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = PTR_FIRST;
      end
    endcase
  end

  assign busy   = (state_q == SCRUB);
  assign clr_we = (state_q == SCRUB);
  assign ptr    = ptr_q;

endmodule

// File: rtl/regfile_scrub.sv
// 2-read/1-write register file with reg 0 tied to zero, display taps and a sequential scrub.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to rd1/rd2.
module regfile_scrub
  import regfile_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 32,
  parameter int NDISP = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we3,
  input  logic [ADDR_W-1:0]   wa3,
  input  logic [N-1:0]        wd3,
  input  logic [ADDR_W-1:0]   ra1,
  input  logic [ADDR_W-1:0]   ra2,
  output logic [N-1:0]        rd1,
  output logic [N-1:0]        rd2,
  input  logic                clr,
  output logic                busy,
  output logic [NDISP*N-1:0]  disp
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [N-1:0]     regs_q [DEPTH];
  logic [N-1:0]     regs_d [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic             clr_we;
  logic             wr_ok;

  regfile_scrub_fsm #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fsm (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .busy   (busy),
    .ptr    (ptr),
    .clr_we (clr_we)
  );

  assign wr_ok = we3 && !busy && (wa3 != '0) && (32'(wa3) < DEPTH);

  // Scrub wins over a write; in practice busy already blocks the write port.
  always_comb begin
    regs_d = regs_q;
    if (clr_we) begin
      regs_d[ptr] = '0;
    end else if (wr_ok) begin
      regs_d[wa3] = wd3;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if ((ra1 != '0) && (32'(ra1) < DEPTH)) begin
      rd1 = regs_q[ra1];
    end
    if ((ra2 != '0) && (32'(ra2) < DEPTH)) begin
      rd2 = regs_q[ra2];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (ra1 == wa3)) begin
      rd1 = wd3;
    end
    if (wr_ok && (ra2 == wa3)) begin
      rd2 = wd3;
    end
`endif
  end

  always_comb begin
    disp = '0;
    for (int k = 0; k < NDISP; k++) begin
      disp[k*N +: N] = regs_q[k];
    end
  end

endmodule

// File: tb/tb_regfile_scrub.sv
// Scoreboard bench for regfile_scrub: a 32-deep instance and a 20-deep instance share stimulus.
module tb_regfile_scrub;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we3, clr;
  logic [4:0] wa3, ra1, ra2;
  logic [7:0] wd3;

  logic [7:0]  rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy_a, busy_b;
  logic [63:0] disp_a, disp_b;

  logic [7:0] m32 [32];
  logic [7:0] m20 [20];
  logic [7:0] exp_q [$];
  logic [7:0] e;
  logic [63:0] exp_disp;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scrub #(.N(8), .DEPTH(32), .NDISP(8)) dut_a (
    .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .clr(clr), .busy(busy_a), .disp(disp_a)
  );

  regfile_scrub #(.N(8), .DEPTH(20), .NDISP(8)) dut_b (
    .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .clr(clr), .busy(busy_b), .disp(disp_b)
  );

  task automatic clear_models();
    for (int i = 0; i < 32; i++) m32[i] = 8'h00;
    for (int i = 0; i < 20; i++) m20[i] = 8'h00;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    we3 = 1'b1; wa3 = a; wd3 = d;
    @(negedge clk);
    we3 = 1'b0;
    if (a != 5'd0) begin
      m32[a] = d;
      if (a < 5'd20) m20[a] = d;
    end
  endtask

  task automatic test_reset();
    do_write(5'd3, 8'h3C);
    do_write(5'd4, 8'h4D);
    ra1 = 5'd3; ra2 = 5'd4;
    #2 rst = 1'b0;
    clear_models();
    exp_q.push_back(m32[3]);
    exp_q.push_back(m32[4]);
    exp_q.push_back(m20[3]);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL reset_rd1 got %h exp %h", rd1_a, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_a !== e) begin errors++; $display("FAIL reset_rd2 got %h exp %h", rd2_a, e); end
    e = exp_q.pop_front(); checks++;
    if (rd1_b !== e) begin errors++; $display("FAIL reset_rd1_d20 got %h exp %h", rd1_b, e); end
    checks++;
    if (disp_a !== 64'h0) begin errors++; $display("FAIL reset_disp got %h exp %h", disp_a, 64'h0); end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    #1 rst = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd3; wd3 = 8'hA5; ra1 = 5'd3; ra2 = 5'd0;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(8'hA5);
`else
    exp_q.push_back(m32[3]);
`endif
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL same_cycle_rd1 got %h exp %h", rd1_a, e); end
    @(negedge clk);
    we3 = 1'b0;
    m32[3] = 8'hA5; m20[3] = 8'hA5;
    exp_q.push_back(m32[3]);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL write_rd1 got %h exp %h", rd1_a, e); end
    checks++;
    if (disp_a[3*8 +: 8] !== 8'hA5) begin
      errors++; $display("FAIL write_disp3 got %h exp %h", disp_a[3*8 +: 8], 8'hA5);
    end
    do_write(5'd17, 8'h5A);
    do_write(5'd1, 8'hC3);
    do_write(5'd31, 8'hE7);
    do_write(5'd7, 8'h71);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      exp_q.push_back(m32[i]);
      exp_q.push_back(m32[31 - i]);
      exp_q.push_back((i < 20) ? m20[i] : 8'h00);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rd1_a !== e) begin errors++; $display("FAIL sweep_rd1 addr %0d got %h exp %h", i, rd1_a, e); end
      e = exp_q.pop_front(); checks++;
      if (rd2_a !== e) begin errors++; $display("FAIL sweep_rd2 addr %0d got %h exp %h", 31 - i, rd2_a, e); end
      e = exp_q.pop_front(); checks++;
      if (rd1_b !== e) begin errors++; $display("FAIL sweep_rd1_d20 addr %0d got %h exp %h", i, rd1_b, e); end
    end
    for (int k = 0; k < 8; k++) exp_disp[k*8 +: 8] = m32[k];
    checks++;
    if (disp_a !== exp_disp) begin errors++; $display("FAIL disp_pack got %h exp %h", disp_a, exp_disp); end
  endtask

  task automatic test_r0_range();
    do_write(5'd0, 8'hFF);
    ra1 = 5'd0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL r0_rd1 got %h exp %h", rd1_a, e); end
    e = exp_q.pop_front(); checks++;
    if (disp_a[7:0] !== e) begin errors++; $display("FAIL r0_disp got %h exp %h", disp_a[7:0], e); end
    do_write(5'd25, 8'h33);
    do_write(5'd19, 8'h19);
    do_write(5'd20, 8'h20);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i);
      exp_q.push_back((i < 20) ? m20[i] : 8'h00);
      exp_q.push_back(m32[i]);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rd1_b !== e) begin errors++; $display("FAIL range_d20 addr %0d got %h exp %h", i, rd1_b, e); end
      e = exp_q.pop_front(); checks++;
      if (rd2_a !== e) begin errors++; $display("FAIL range_d32 addr %0d got %h exp %h", i, rd2_a, e); end
    end
  endtask

  task automatic test_scrub();
    int n;
    for (int i = 1; i < 32; i++) do_write(5'(i), 8'(i));
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      if (n == 5) begin
        ra1 = 5'd5; ra2 = 5'd6;
        exp_q.push_back(8'h00); exp_q.push_back(8'h06);
        exp_q.push_back(8'h00); exp_q.push_back(8'h06);
        #1;
        e = exp_q.pop_front(); checks++;
        if (rd1_a !== e) begin errors++; $display("FAIL mid_scrub_r5 got %h exp %h", rd1_a, e); end
        e = exp_q.pop_front(); checks++;
        if (rd2_a !== e) begin errors++; $display("FAIL mid_scrub_r6 got %h exp %h", rd2_a, e); end
        e = exp_q.pop_front(); checks++;
        if (rd1_b !== e) begin errors++; $display("FAIL mid_scrub_r5_d20 got %h exp %h", rd1_b, e); end
        e = exp_q.pop_front(); checks++;
        if (rd2_b !== e) begin errors++; $display("FAIL mid_scrub_r6_d20 got %h exp %h", rd2_b, e); end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 31) begin errors++; $display("FAIL scrub_busy_cycles got %0d exp %0d", n, 31); end
    checks++;
    if (busy_b !== 1'b0) begin errors++; $display("FAIL scrub_busy_d20 got %b exp 0", busy_b); end
    clear_models();
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i);
      exp_q.push_back(m32[i]);
      exp_q.push_back((i < 20) ? m20[i] : 8'h00);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rd1_a !== e) begin errors++; $display("FAIL scrub_clear addr %0d got %h exp %h", i, rd1_a, e); end
      e = exp_q.pop_front(); checks++;
      if (rd2_b !== e) begin errors++; $display("FAIL scrub_clear_d20 addr %0d got %h exp %h", i, rd2_b, e); end
    end
  endtask

  task automatic test_stall();
    int n;
    // Write and clr in the same IDLE cycle: write lands first, scrub later zeroes it.
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd7; wd3 = 8'h77; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; wa3 = 5'd31;
    ra1 = 5'd7;
    exp_q.push_back(8'h77);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL write_with_clr got %h exp %h", rd1_a, e); end
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      if (n == 5) wa3 = 5'd3;
      if (n == 10) clr = 1'b1;
      if (n == 11) clr = 1'b0;
      @(negedge clk);
      n++;
    end
    we3 = 1'b0; clr = 1'b0;
    checks++;
    if (n != 31) begin errors++; $display("FAIL stall_busy_cycles got %0d exp %0d", n, 31); end
    clear_models();
    // The 20-deep file finished early, so its reg3 took the held write afterwards.
    m20[3] = 8'h77;
    ra1 = 5'd31; ra2 = 5'd3;
    exp_q.push_back(m32[31]); exp_q.push_back(m32[3]); exp_q.push_back(m20[3]);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL stall_r31 got %h exp %h", rd1_a, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_a !== e) begin errors++; $display("FAIL stall_r3 got %h exp %h", rd2_a, e); end
    e = exp_q.pop_front(); checks++;
    if (rd2_b !== e) begin errors++; $display("FAIL stall_r3_d20 got %h exp %h", rd2_b, e); end
    ra1 = 5'd7;
    exp_q.push_back(m32[7]);
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd1_a !== e) begin errors++; $display("FAIL clr_after_write_r7 got %h exp %h", rd1_a, e); end
  endtask

  task automatic test_reset_mid_scrub();
    int n;
    for (int i = 1; i < 32; i++) do_write(5'(i), 8'(i + 8'h40));
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 10) begin errors++; $display("FAIL pre_reset_busy got %0d exp %0d", n, 10); end
    #2 rst = 1'b0;
    clear_models();
    #1;
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b exp 0", busy_a); end
    checks++;
    if (disp_a !== 64'h0) begin errors++; $display("FAIL mid_reset_disp got %h exp %h", disp_a, 64'h0); end
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i);
      exp_q.push_back(m32[i]);
      exp_q.push_back((i < 20) ? m20[i] : 8'h00);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rd1_a !== e) begin errors++; $display("FAIL mid_reset_reg addr %0d got %h exp %h", i, rd1_a, e); end
      e = exp_q.pop_front(); checks++;
      if (rd2_b !== e) begin errors++; $display("FAIL mid_reset_reg_d20 addr %0d got %h exp %h", i, rd2_b, e); end
    end
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 31) begin errors++; $display("FAIL restart_busy_cycles got %0d exp %0d", n, 31); end
  endtask

  initial begin
    we3 = 1'b0; clr = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
    clear_models();
    #12 rst = 1'b1;
    test_reset();
    test_write_read();
    test_r0_range();
    test_scrub();
    test_stall();
    test_reset_mid_scrub();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
